// File: rtl/fp10_stream_acc_pkg.sv
// Shared constants, state encoding and field helpers for the fp10 accumulator.
package fp10_stream_acc_pkg;

  localparam int FP_M    = 4;
  localparam int EXT_W   = 8;
  localparam int HID_IDX = 7;
  localparam int G_IDX   = 2;
  localparam int R_IDX   = 1;
  localparam int S_IDX   = 0;

  localparam logic [8:0] MAXFIN_MAG = 9'h1EF;
  localparam logic [8:0] INF_MAG    = 9'h1F0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // 1.mmmm followed by clear guard, round and sticky bits
  function automatic logic [EXT_W-1:0] ext_man(input logic [FP_M-1:0] m);
    return {1'b1, m, 3'b000};
  endfunction

endpackage

// File: rtl/fp10_lzc.sv
// Leading-zero count of the 8-bit extended mantissa; an all-zero input yields 8.
module fp10_lzc
  import fp10_stream_acc_pkg::*;
(
  input  logic [EXT_W-1:0] man,
  output logic [3:0]       cnt
);

  always_comb begin
    cnt = 4'd8;
    for (int i = 0; i < EXT_W; i++) begin
      if (man[i]) cnt = 4'(EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp10_stream_acc.sv
// Multicycle fp10 stream accumulator (align/add/normalise/round FSM, one operand per 5 cycles).
// Build option FP10_ACC_SAT_EN: overflow saturates to max finite instead of infinity.
module fp10_stream_acc
  import fp10_stream_acc_pkg::*;
#(
  parameter int N     = 10,
  parameter int E     = 5,
  parameter int M     = 4,
  parameter int BIAS  = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int EXPW = E + 2;
  localparam logic [E-1:0]           EXP_INF   = E'(2 * BIAS + 1);
  localparam logic signed [EXPW-1:0] EXP_INF_S = EXPW'(2 * BIAS + 1);

  function automatic logic [EXT_W-1:0] align_shift(input logic [EXT_W-1:0] man,
                                                   input logic [E-1:0] diff);
    logic [EXT_W-1:0] shifted;
    logic [EXT_W-1:0] lost;
    if (diff > E'(EXT_W - 1)) return {{(EXT_W-1){1'b0}}, |man};
    shifted = man >> diff;
    lost    = man & ~({EXT_W{1'b1}} << diff);
    return {shifted[EXT_W-1:1], shifted[0] | (|lost)};
  endfunction

  // returns {mantissa carry, rounded stored mantissa}
  function automatic logic [M:0] round_ne(input logic [EXT_W-1:0] man);
    logic         inc;
    logic [M+1:0] sum;
    inc = man[G_IDX] & (man[R_IDX] | man[S_IDX] | man[G_IDX+1]);
    sum = {1'b0, man[HID_IDX -: M+1]} + (M+2)'(inc);
    return sum[M+1] ? {1'b1, sum[M:1]} : {1'b0, sum[M-1:0]};
  endfunction

  function automatic logic [N-1:0] ovf_value(input logic s);
`ifdef FP10_ACC_SAT_EN
    return {s, MAXFIN_MAG};
`else
    return {s, INF_MAG};
`endif
  endfunction

  state_t state_q, state_d;

  logic [N-1:0]     acc_q, op_q, acc_d;
  logic             last_q, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-2:0]     acc_key, op_key;
  logic [EXT_W-1:0] acc_man, op_man, big_man, small_man;
  logic [E-1:0]     big_exp, small_exp;
  logic             acc_zero, op_zero, op_inf, swap, big_sign, small_sign;

  logic             sign_p0, sub_p0;
  logic [E-1:0]     exp_p0;
  logic [EXT_W-1:0] big_p0, small_p0;

  logic             sign_p1;
  logic [E-1:0]     exp_p1;
  logic [EXT_W:0]   sum_p1;

  logic                   sign_p2, zero_p2;
  logic signed [EXPW-1:0] exp_p2;
  logic [EXT_W-1:0]       man_p2;

  logic [3:0]             lzc;
  logic [EXT_W-1:0]       norm_man;
  logic signed [EXPW-1:0] norm_exp, exp_r;
  logic [M:0]             rnd;

  assign in_ready = (state_q == ST_IDLE);

  fp10_lzc u_lzc (
    .man (sum_p1[EXT_W-1:0]),
    .cnt (lzc)
  );

  // order |acc| and |op|; exponent zero means the value is zero
  always_comb begin
    acc_zero   = (acc_q[M +: E] == '0);
    op_zero    = (op_q[M +: E] == '0);
    op_inf     = (op_q[M +: E] == EXP_INF);
    acc_key    = acc_zero ? '0 : acc_q[N-2:0];
    op_key     = op_zero ? '0 : op_q[N-2:0];
    acc_man    = acc_zero ? '0 : ext_man(acc_q[M-1:0]);
    op_man     = op_zero ? '0 : ext_man(op_q[M-1:0]);
    swap       = (op_key > acc_key);
    big_sign   = swap ? op_q[N-1] : acc_q[N-1];
    small_sign = swap ? acc_q[N-1] : op_q[N-1];
    big_exp    = swap ? op_key[N-2:M] : acc_key[N-2:M];
    small_exp  = swap ? acc_key[N-2:M] : op_key[N-2:M];
    big_man    = swap ? op_man : acc_man;
    small_man  = swap ? acc_man : op_man;
  end

  always_comb begin
    norm_man = sum_p1[EXT_W-1:0] << lzc;
    norm_exp = $signed({2'b00, exp_p1} - {{(E-2){1'b0}}, lzc});
    if (sum_p1[EXT_W]) begin
      norm_man = {sum_p1[EXT_W:2], sum_p1[1] | sum_p1[0]};
      norm_exp = $signed({2'b00, exp_p1} + {{(E+1){1'b0}}, 1'b1});
    end
  end

  // once overflowed, acc stays pinned until the result is handed off
  always_comb begin
    rnd   = round_ne(man_p2);
    exp_r = exp_p2 + $signed({{(E+1){1'b0}}, rnd[M]});
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    if (ovf_q) begin
      acc_d = acc_q;
    end else if (op_inf) begin
      ovf_d = 1'b1;
      acc_d = ovf_value(op_q[N-1]);
    end else if (zero_p2 || exp_r[EXPW-1] || exp_r == '0) begin
      acc_d = '0;
    end else if (exp_r >= EXP_INF_S) begin
      ovf_d = 1'b1;
      acc_d = ovf_value(sign_p2);
    end else begin
      acc_d = {sign_p2, exp_r[E-1:0], rnd[M-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      op_q   <= in_data;
      last_q <= in_last;
    end
    // ALIGN -> ADD
    if (state_q == ST_ALIGN) begin
      sign_p0  <= big_sign;
      sub_p0   <= big_sign ^ small_sign;
      exp_p0   <= big_exp;
      big_p0   <= big_man;
      small_p0 <= align_shift(small_man, big_exp - small_exp);
    end
    // ADD -> NORM
    if (state_q == ST_ADD) begin
      sign_p1 <= sign_p0;
      exp_p1  <= exp_p0;
      sum_p1  <= sub_p0 ? {1'b0, big_p0} - {1'b0, small_p0}
                        : {1'b0, big_p0} + {1'b0, small_p0};
    end
    // NORM -> ROUND
    if (state_q == ST_NORM) begin
      zero_p2 <= (sum_p1 == '0);
      sign_p2 <= (sum_p1 == '0) ? 1'b0 : sign_p1;
      exp_p2  <= norm_exp;
      man_p2  <= norm_man;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ROUND) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        if (last_q) begin
          out_valid <= 1'b1;
          out_data  <= acc_d;
          out_cnt   <= cnt_d;
          out_ovf   <= ovf_d;
        end
      end
      if (state_q == ST_DONE && out_ready) begin
        acc_q     <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp10_stream_acc.sv
// Scoreboard bench for fp10_stream_acc: directed streams with hand-computed sums.
module tb_fp10_stream_acc;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [9:0] in_data, out_data;
  logic [7:0] out_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [9:0] d;
    logic       o;
    logic [7:0] c;
  } exp_t;
  exp_t exp_q[$];

`ifdef FP10_ACC_SAT_EN
  localparam logic [9:0] OVF_POS = 10'h1EF;
`else
  localparam logic [9:0] OVF_POS = 10'h1F0;
`endif
  localparam logic [9:0] OVF_NEG = OVF_POS | 10'h200;

  fp10_stream_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [9:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for operand 0x%0h, required 1", d);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic stream2(input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] ed, input logic eo, input logic [7:0] ec);
    send(a, 1'b0);
    exp_q.push_back('{ed, eo, ec});
    send(b, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h with nothing pending, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_ovf", 32'(out_ovf), 32'(e.o));
        chk("out_cnt", 32'(out_cnt), 32'(e.c));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hs, first;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_out_cnt", 32'(out_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    stream2(10'h0F0, 10'h0F0, 10'h100, 1'b0, 8'd2);
    stream2(10'h0F8, 10'h0F8, 10'h108, 1'b0, 8'd2);
    stream2(10'h0F0, 10'h2F0, 10'h000, 1'b0, 8'd2);
    stream2(10'h0F0, 10'h090, 10'h0F0, 1'b0, 8'd2);
    stream2(10'h0F0, 10'h0A0, 10'h0F0, 1'b0, 8'd2);
    stream2(10'h0F1, 10'h0A0, 10'h0F2, 1'b0, 8'd2);
    stream2(10'h018, 10'h211, 10'h000, 1'b0, 8'd2);
    stream2(10'h1EF, 10'h1EF, OVF_POS, 1'b1, 8'd2);
    stream2(10'h3EF, 10'h3EF, OVF_NEG, 1'b1, 8'd2);
    stream2(10'h1F0, 10'h0F0, OVF_POS, 1'b1, 8'd2);
    send(10'h0F0, 1'b0);
    send(10'h0F0, 1'b0);
    exp_q.push_back('{10'h108, 1'b0, 8'd3});
    send(10'h0F0, 1'b1);
    drain();

    // stalled consumer, then back-to-back acceptance timing
    out_ready = 1'b0;
    stream2(10'h0F0, 10'h0F0, 10'h100, 1'b0, 8'd2);
    repeat (3) @(posedge clk);
    #1 chk("latency_t3_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1 chk("latency_t4_out_valid", 32'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_data", 32'(out_data), 32'h100);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_data = 10'h0F0;
    in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 hs = cyc;
    send(10'h0F0, 1'b0);
    chk("accept_after_handshake", 32'(acc_cyc), 32'(hs + 1));
    first = acc_cyc;
    exp_q.push_back('{10'h100, 1'b0, 8'd2});
    send(10'h0F0, 1'b1);
    chk("operand_spacing", 32'(acc_cyc - first), 5);
    drain();

    // reset in the middle of a three-operand stream
    send(10'h100, 1'b0);
    send(10'h100, 1'b0);
    send(10'h0F0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_ovf", 32'(out_ovf), 0);
    chk("midrst_out_cnt", 32'(out_cnt), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    exp_q.push_back('{10'h0F0, 1'b0, 8'd1});
    send(10'h0F0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
